// File: rtl/writeback_stage.sv
// writeback_stage: EX/WB pipeline register and register-file write-back driver.
//
// The stage captures the EX instruction and its ALU result on each clock edge.
// In the following cycle it drives the register-file write port, so every
// retiring write instruction produces a write pulse exactly one cycle wide.
// It also forwards the WB result to ID, which covers the case where the
// register file is written and read in the same cycle. A saturating counter
// tracks how many instructions have retired.
//
// Ports:
//   Clk            rising-edge clock
//   Reset          synchronous, active-high reset
//   Instr_Code_EX  EX instruction: [7:6] opcode, [2:0] destination register
//   ALU_Result     EX result that belongs to Instr_Code_EX
//   EX_Valid       EX holds a real instruction (0 = bubble)
//   Stall          EX is held this cycle, so WB takes a bubble
//   Flush          kill the instruction that is entering WB
//   Instr_Code_ID  ID instruction: [7:6] opcode, [5:3] source register
//   RegWrite       register-file write enable
//   Write_Reg_Num  register-file write address
//   Write_Data     register-file write data
//   Fwd_Sel        ID uses Fwd_Data instead of the register-file read
//   Fwd_Data       forwarded value (the WB result)
//   Retired_Count  instructions retired since reset, saturating
module writeback_stage #(
  parameter int unsigned CNT_W       = 16,
  parameter logic [1:0]  NOWB_OPCODE = 2'b11
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       Instr_Code_EX,
  input  logic [7:0]       ALU_Result,
  input  logic             EX_Valid,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [7:0]       Instr_Code_ID,
  output logic             RegWrite,
  output logic [2:0]       Write_Reg_Num,
  output logic [7:0]       Write_Data,
  output logic             Fwd_Sel,
  output logic [7:0]       Fwd_Data,
  output logic [CNT_W-1:0] Retired_Count
);

  logic             wb_valid_q,  wb_valid_d;
  logic [7:0]       wb_instr_q,  wb_instr_d;
  logic [7:0]       wb_result_q, wb_result_d;
  logic [CNT_W-1:0] count_q,     count_d;

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_instr_d  = wb_instr_q;
    wb_result_d = wb_result_q;
    count_d     = count_q;

    if (Flush || Stall) begin
      // A stalled EX presents its instruction again later, so the WB slot
      // becomes a bubble. The instruction and result registers hold.
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d  = EX_Valid;
      wb_instr_d  = Instr_Code_EX;
      wb_result_d = ALU_Result;
    end

    // Every instruction that leaves WB retires, including jumps. The count
    // stops at all-ones and never wraps.
    if (wb_valid_q && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wb_valid_q  <= 1'b0;
      wb_instr_q  <= '0;
      wb_result_q <= '0;
      count_q     <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_instr_q  <= wb_instr_d;
      wb_result_q <= wb_result_d;
      count_q     <= count_d;
    end
  end

  assign RegWrite      = wb_valid_q && (wb_instr_q[7:6] != NOWB_OPCODE);
  assign Write_Reg_Num = wb_instr_q[2:0];
  assign Write_Data    = wb_result_q;

  assign Fwd_Sel  = RegWrite
                 && (wb_instr_q[2:0] == Instr_Code_ID[5:3])
                 && (Instr_Code_ID[7:6] != NOWB_OPCODE);
  assign Fwd_Data = wb_result_q;

  assign Retired_Count = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  Instr_Code_EX = '0;
  logic [7:0]  ALU_Result = '0;
  logic        EX_Valid = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [7:0]  Instr_Code_ID = '0;

  logic        rw_a, rw_b, fs_a, fs_b;
  logic [2:0]  rn_a, rn_b;
  logic [7:0]  wd_a, wd_b, fd_a, fd_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 Clk = ~Clk;

  writeback_stage #(.CNT_W(16), .NOWB_OPCODE(2'b11)) dut (
    .Clk(Clk), .Reset(Reset), .Instr_Code_EX(Instr_Code_EX), .ALU_Result(ALU_Result),
    .EX_Valid(EX_Valid), .Stall(Stall), .Flush(Flush), .Instr_Code_ID(Instr_Code_ID),
    .RegWrite(rw_a), .Write_Reg_Num(rn_a), .Write_Data(wd_a),
    .Fwd_Sel(fs_a), .Fwd_Data(fd_a), .Retired_Count(cnt_a)
  );

  writeback_stage #(.CNT_W(4), .NOWB_OPCODE(2'b11)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Instr_Code_EX(Instr_Code_EX), .ALU_Result(ALU_Result),
    .EX_Valid(EX_Valid), .Stall(Stall), .Flush(Flush), .Instr_Code_ID(Instr_Code_ID),
    .RegWrite(rw_b), .Write_Reg_Num(rn_b), .Write_Data(wd_b),
    .Fwd_Sel(fs_b), .Fwd_Data(fd_b), .Retired_Count(cnt_b)
  );

  typedef struct {
    bit         known;
    bit         after_reset;
    bit         rw;
    bit [2:0]   rn;
    bit [7:0]   wd;
    bit         fs;
    bit [7:0]   fd;
    int         cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // The reference model tracks which instruction currently occupies WB
  // and how many instructions have left WB since the last reset.
  bit       m_known = 0;
  bit       m_after_reset = 0;
  bit       m_occupied = 0;
  bit       m_writes = 0;
  bit [2:0] m_dest = 0;
  bit [7:0] m_value = 0;
  int       m_retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, record what the outputs must be during this
  // cycle, and then advance the model past the upcoming clock edge.
  task automatic cyc(input bit rst, input bit [7:0] ex, input bit [7:0] alu, input bit v,
                     input bit st, input bit fl, input bit [7:0] id);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = rst; Instr_Code_EX = ex; ALU_Result = alu; EX_Valid = v;
    Stall = st; Flush = fl; Instr_Code_ID = id;

    e.known       = m_known;
    e.after_reset = m_after_reset;
    e.rw          = m_occupied && m_writes;
    e.rn          = m_dest;
    e.wd          = m_value;
    e.fs          = e.rw && (m_dest == id[5:3]) && (id[7:6] != 2'b11);
    e.fd          = m_value;
    e.cnt         = m_retired;
    sb.push_back(e);

    if (rst) begin
      m_known = 1; m_after_reset = 1; m_occupied = 0; m_retired = 0;
      m_dest = 0; m_value = 0; m_writes = 1;
    end else if (m_known) begin
      m_after_reset = 0;
      if (m_occupied) m_retired++;
      if (!st && !fl && v) begin
        m_occupied = 1;
        m_writes   = (ex[7:6] != 2'b11);
        m_dest     = ex[2:0];
        m_value    = alu;
      end else begin
        m_occupied = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; compare it
  // against the oldest pending expectation.
  initial begin
    exp_t e;
    int c16, c4;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.known) begin
          c16 = (e.cnt > 65535) ? 65535 : e.cnt;
          c4  = (e.cnt > 15) ? 15 : e.cnt;
          chk("regwrite", 32'(rw_a), 32'(e.rw));
          chk("fwd_sel", 32'(fs_a), 32'(e.fs));
          chk("count16", 32'(cnt_a), 32'(c16));
          chk("count4", 32'(cnt_b), 32'(c4));
          chk("regwrite_sat_inst", 32'(rw_b), 32'(e.rw));
          if (e.rw) begin
            chk("write_reg", 32'(rn_a), 32'(e.rn));
            chk("write_data", 32'(wd_a), 32'(e.wd));
          end
          if (e.fs) chk("fwd_data", 32'(fd_a), 32'(e.fd));
          if (e.after_reset) begin
            chk("reset_reg", 32'(rn_a), 32'd0);
            chk("reset_data", 32'(wd_a), 32'd0);
            chk("reset_fwd_data", 32'(fd_a), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    // Reset priority over a valid EX instruction.
    cyc(1, 8'h05, 8'hAA, 1, 0, 0, 8'h00);
    cyc(1, 8'h05, 8'hAA, 1, 0, 0, 8'h00);
    idle(2);

    // Basic write of reg 3.
    cyc(0, 8'b01_000_011, 8'h3C, 1, 0, 0, 8'h00);
    idle(2);

    // Jump counts but never writes; a bubble does neither.
    cyc(0, 8'b11_000_101, 8'h11, 1, 0, 0, 8'h00);
    cyc(0, 8'b11_000_101, 8'h11, 0, 0, 0, 8'h00);
    idle(2);

    // Stall for 3 cycles, then release: one pulse to reg 2.
    for (int i = 0; i < 3; i++) cyc(0, 8'b00_001_010, 8'h5A, 1, 1, 0, 8'h00);
    cyc(0, 8'b00_001_010, 8'h5A, 1, 0, 0, 8'h00);
    idle(2);

    // Flush together with Stall, then Flush of a valid instruction.
    cyc(0, 8'b00_000_110, 8'h66, 1, 1, 1, 8'h00);
    cyc(0, 8'b00_000_111, 8'h67, 1, 0, 1, 8'h00);
    idle(2);

    // Forwarding: matching source, different source, jump in ID.
    cyc(0, 8'b01_000_100, 8'h77, 1, 0, 0, 8'h00);
    cyc(0, 8'h00, 8'h00, 0, 0, 0, 8'b01_100_001);
    cyc(0, 8'b01_000_100, 8'h77, 1, 0, 0, 8'h00);
    cyc(0, 8'h00, 8'h00, 0, 0, 0, 8'b01_011_001);
    cyc(0, 8'b01_000_100, 8'h77, 1, 0, 0, 8'h00);
    cyc(0, 8'h00, 8'h00, 0, 0, 0, 8'b11_100_001);
    idle(1);

    // Back-to-back writes followed by saturation of the narrow counter.
    for (int i = 0; i < 20; i++)
      cyc(0, {2'b10, 3'b000, 3'(i)}, 8'(i * 7 + 1), 1, 0, 0, {2'b00, 3'(i + 1), 3'b000});
    idle(3);

    // Mid-stream reset discards the in-flight write.
    cyc(0, 8'b01_000_001, 8'h99, 1, 0, 0, 8'h00);
    cyc(1, 8'b01_000_010, 8'h98, 1, 0, 0, 8'h00);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit [7:0] ex, alu, id;
      bit rst, st, fl, v;
      ex  = 8'($urandom);
      alu = 8'($urandom);
      id  = 8'($urandom);
      if ($urandom_range(0, 1) == 0) id[5:3] = ex[2:0];
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 15);
      fl  = ($urandom_range(0, 99) < 10);
      v   = ($urandom_range(0, 99) < 75);
      cyc(rst, ex, alu, v, st, fl, id);
    end
    idle(2);

    @(negedge Clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- EX/WB pipeline register and write-back driver: the producer side of the register-file write port.
- Captures the EX-stage instruction and ALU result each cycle, then drives RegWrite / Write_Reg_Num / Write_Data into the register file for exactly one cycle per retiring instruction.
- Also supplies an ID-stage forwarding path, which hides the same-cycle write/read race in the register file, and a saturating retired-instruction counter.

Parameters:
- CNT_W, 16, width of Retired_Count.
- NOWB_OPCODE, 2'b11, opcode value that never writes a register (jump).

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Instr_Code_EX  in  8  instruction in EX; [7:6] opcode, [2:0] destination register
- ALU_Result  in  8  EX result for Instr_Code_EX
- EX_Valid  in  1  EX holds a real instruction (0 = bubble)
- Stall  in  1  EX is held this cycle; WB must take a bubble
- Flush  in  1  kill the instruction entering WB
- Instr_Code_ID  in  8  instruction in ID; [7:6] opcode, [5:3] source register
- RegWrite  out  1  register-file write enable
- Write_Reg_Num  out  3  register-file write address
- Write_Data  out  8  register-file write data
- Fwd_Sel  out  1  ID must use Fwd_Data instead of the register-file read
- Fwd_Data  out  8  forwarded value
- Retired_Count  out  CNT_W  instructions retired since reset, saturating

Behaviour:
- Internal state: WB_Valid (1 bit), WB_Instr (8 bits), WB_Result (8 bits), counter (CNT_W bits). All update on the rising edge of Clk.

Priority each edge: Reset > Flush > Stall > normal.
- Reset: WB_Valid=0, WB_Instr=0, WB_Result=0, counter=0. Every output reads 0 in the following cycle.
- Flush: WB_Valid=0. WB_Instr and WB_Result are don't-care, but are held.
- Stall: WB_Valid=0 (bubble). EX is holding its instruction and presents it again when Stall drops, so no instruction is ever written twice.
- Normal: WB_Valid=EX_Valid, WB_Instr=Instr_Code_EX, WB_Result=ALU_Result.
- Reset asserted mid-stream discards the in-flight WB entry; no write occurs in the cycle after Reset.

Outputs (combinational from registers, latency 1 cycle from EX capture):
- RegWrite = WB_Valid AND (WB_Instr[7:6] != NOWB_OPCODE).
- Write_Reg_Num = WB_Instr[2:0].
- Write_Data = WB_Result.
- When RegWrite=0, Write_Reg_Num and Write_Data still show the register contents. The register file ignores them.
- Each valid write instruction gives exactly one RegWrite pulse, one cycle wide. Back-to-back valid instructions give RegWrite high on consecutive cycles with new address and data each cycle.

Forwarding (combinational):
- Fwd_Sel = RegWrite AND (Write_Reg_Num == Instr_Code_ID[5:3]) AND (Instr_Code_ID[7:6] != NOWB_OPCODE).
- Fwd_Data = WB_Result.
- Fwd_Sel is 0 whenever RegWrite is 0, including bubbles, flushed slots, jumps and reset.

Retired counter:
- Increments by 1 on an edge where WB_Valid=1 at that edge (jumps count; bubbles do not).
- Holds at 2^CNT_W-1 and never wraps.
- Retired_Count = counter.

Test Plan:
- Reset priority: Reset=1 for 2 cycles with EX_Valid=1, Instr_Code_EX=8'h05, ALU_Result=8'hAA -> RegWrite=0, Retired_Count=0, Write_Data=0 after release.
- Basic write: EX_Valid=1, Instr_Code_EX=8'b01_000_011, ALU_Result=8'h3C for one cycle -> next cycle RegWrite=1, Write_Reg_Num=3, Write_Data=8'h3C; following cycle RegWrite=0; Retired_Count=1.
- Jump and bubble: Instr_Code_EX=8'b11_000_101, EX_Valid=1 -> RegWrite stays 0, Retired_Count increments. Then EX_Valid=0 -> no increment.
- Stall and Flush: Stall=1 while EX holds 8'b00_001_010 for 3 cycles, then Stall=0 -> exactly one RegWrite pulse (reg 2). Flush=1 with Stall=1 -> no pulse. Flush=1 with valid EX -> no write, no count.
- Forwarding: WB writes reg 4 = 8'h77, Instr_Code_ID=8'b01_100_001 -> Fwd_Sel=1, Fwd_Data=8'h77. With Instr_Code_ID=8'b01_011_001 -> Fwd_Sel=0. With Instr_Code_ID=8'b11_100_001 -> Fwd_Sel=0.
- Saturation: CNT_W=4, 20 consecutive valid instructions -> Retired_Count reaches 15 and holds at 15.
